// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run-control sequencer for the 8-bit up/down counter.
//
// On every divider tick (a 1-cycle enable, not a clock) it decides whether
// the counter steps, reloads or holds. It also tracks run status for the
// LED/display layer.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   tick                1-cycle enable pulse from clock_divider
//   start, stop         1-cycle commands (priority: stop > start > tick)
//   up                  direction switch, 1 = count up
//   mode                00 WRAP, 01 SATURATE, 10 BOUNCE, 11 ONESHOT
//   lo_lim, hi_lim      counting window bounds
//   q                   counter value fed back from the datapath
//   step, cnt_up        1-cycle step strobe and direction to the counter
//   load, load_val      1-cycle reload strobe and reload value
//   running, done       state == RUN / state == DONE
//   lim_hit             1-cycle pulse when a tick finds the counter at a limit
//   cfg_err             lo_lim > hi_lim
//   state_o             current FSM state, for debug and checkers
//
// Interface semantics: there is no valid/ready handshake.
// - tick, start and stop are single-cycle pulses. They are sampled on the clock
//   edge on which they are high.
// - A command (start or stop) in the same cycle as a tick wins, and the tick
//   is dropped.
// - step, load and lim_hit are single-cycle pulses. They appear one clock after
//   the cycle that caused them.
// - The counter applies step or load on the edge after that.
// - Because tick pulses are at least MIN_TICK_GAP cycles apart, q has settled
//   by the time the next tick is evaluated.
module count_seq_ctrl #(
  parameter int W            = 8,
  parameter int MIN_TICK_GAP = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic [W-1:0] lo_lim,
  input  logic [W-1:0] hi_lim,
  input  logic [W-1:0] q,
  output logic         step,
  output logic         cnt_up,
  output logic         load,
  output logic [W-1:0] load_val,
  output logic         running,
  output logic         done,
  output logic         lim_hit,
  output logic         cfg_err,
  output logic [1:0]   state_o
);

  // The feedback path needs two edges per tick: the strobe edge, then the
  // counter update edge. Closer ticks would evaluate a stale q.
  if (MIN_TICK_GAP < 2) begin : g_gap_chk
    $error("count_seq_ctrl: MIN_TICK_GAP must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  state_t         state_q, state_d;
  logic           step_q, step_d;
  logic           cnt_up_q, cnt_up_d;
  logic           load_q, load_d;
  logic [W-1:0]   load_val_q, load_val_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           lim_hit_q, lim_hit_d;
  logic           cfg_err_q;

  logic           bad_cfg;
  logic           tick_dir;
  logic           out_win;
  logic           at_lim;
  logic [W-1:0]   dir_bound;

  assign bad_cfg = (lo_lim > hi_lim);

  // BOUNCE owns its direction. Every other mode follows the switch from
  // the tick onward, so the limit test uses the direction about to be driven.
  assign tick_dir  = (mode == MODE_BOUNCE) ? cnt_up_q : up;

  // An out-of-window value, for example after the limits moved, counts as a limit.
  assign out_win   = (q < lo_lim) || (q > hi_lim);
  assign at_lim    = out_win || (tick_dir ? (q == hi_lim) : (q == lo_lim));

  // The reload target is the starting bound for the direction of travel.
  assign dir_bound = tick_dir ? lo_lim : hi_lim;

  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    load_d     = 1'b0;
    lim_hit_d  = 1'b0;
    cnt_up_d   = cnt_up_q;
    load_val_d = load_val_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start && !bad_cfg) begin
          cnt_up_d   = up;
          load_d     = 1'b1;
          load_val_d = up ? lo_lim : hi_lim;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          // Already running: start is a no-op, and it still drops the tick.
        end else if (tick) begin
          lim_hit_d = at_lim;
          if (mode != MODE_BOUNCE) begin
            cnt_up_d = up;
          end
          if (!at_lim) begin
            step_d = 1'b1;
          end else begin
            case (mode)
              MODE_WRAP: begin
                load_d     = 1'b1;
                load_val_d = dir_bound;
              end
              MODE_SAT: begin
                // Hold at the limit while staying in RUN.
              end
              MODE_BOUNCE: begin
                if (out_win) begin
                  load_d     = 1'b1;
                  load_val_d = dir_bound;
                end else begin
                  // Reverse, and take the first step in the new direction
                  // on this same strobe.
                  cnt_up_d = !cnt_up_q;
                  step_d   = 1'b1;
                end
              end
              MODE_ONESHOT: begin
                state_d = ST_DONE;
              end
              default: begin
              end
            endcase
          end
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          // Resume from the held q, so there is no reload.
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 1'b0;
      cnt_up_q   <= 1'b1;
      load_q     <= 1'b0;
      load_val_q <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      lim_hit_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_up_q   <= cnt_up_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      running_q  <= running_d;
      done_q     <= done_d;
      lim_hit_q  <= lim_hit_d;
      cfg_err_q  <= bad_cfg;
    end
  end

  assign step     = step_q;
  assign cnt_up   = cnt_up_q;
  assign load     = load_q;
  assign load_val = load_val_q;
  assign running  = running_q;
  assign done     = done_q;
  assign lim_hit  = lim_hit_q;
  assign cfg_err  = cfg_err_q;
  assign state_o  = state_q;

endmodule
